// File: rtl/mem_arbiter_pkg.sv
// Shared widths, counter size and FSM encoding
// for the SRAM arbiter slice.
package mem_arbiter_pkg;

  localparam int ADDRESS_LEN = 32;
  localparam int WORD_LEN    = 32;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing one SRAM access;
// zero flags the last access cycle.
module mem_wait_counter
  import mem_arbiter_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one shared
// SRAM; the data port wins simultaneous requests.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = ADDRESS_LEN,
  parameter int DATA_W      = WORD_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_cs_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              grant_d
);

  arb_state_t state;
  arb_state_t nxt;

  logic grant;
  logic sel_d;
  logic cnt_dec;
  logic cnt_zero;
  logic capture;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              owner_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              in_access;

  mem_wait_counter #(
    .W(CNT_W)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .load    (grant),
    .load_val(CNT_W'(WAIT_CYCLES - 1)),
    .dec     (cnt_dec),
    .zero    (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt     = state;
    grant   = 1'b0;
    sel_d   = 1'b0;
    cnt_dec = 1'b0;
    capture = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (d_req) begin
          grant = 1'b1;
          sel_d = 1'b1;
          nxt   = ST_ACCESS;
        end else if (i_req) begin
          grant = 1'b1;
          nxt   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          capture = !we_q;
          nxt     = ST_DONE;
        end
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Requester inputs are only looked at on the grant edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
    end else if (grant) begin
      addr_q  <= sel_d ? d_addr : i_addr;
      wdata_q <= sel_d ? d_wdata : '0;
      we_q    <= sel_d & d_we;
      owner_q <= sel_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (capture) begin
      if (owner_q) begin
        d_rdata_q <= sram_rdata;
      end else begin
        i_rdata_q <= sram_rdata;
      end
    end
  end

  assign in_access  = (state == ST_ACCESS);
  assign sram_cs_n  = !in_access;
  assign sram_oe_n  = !(in_access && !we_q);
  assign sram_we_n  = !(in_access && we_q);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  assign i_ack   = (state == ST_DONE) && !owner_q;
  assign d_ack   = (state == ST_DONE) && owner_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state != ST_IDLE);
  assign grant_d = owner_q;

endmodule
